// File: rtl/sar_scan_if.sv
// Conversion-sequencer bus: host controls, analog front-end controls,
// SAR result input and the tagged result handshake.
// The sequencer connects through the slave modport; the host side
// (or a bench) uses the master modport.
interface sar_scan_if #(
  parameter int PRECISION = 10,
  parameter int NUM_CH    = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                 start;
  logic                 continuous;
  logic                 abort;
  logic [NUM_CH-1:0]    ch_mask;
  logic [CH_W-1:0]      ch_sel;
  logic                 sample;
  logic                 sar_rst;
  logic [PRECISION-1:0] sar_data;
  logic [PRECISION-1:0] res_data;
  logic [CH_W-1:0]      res_ch;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;
  logic                 scan_done;
  logic                 overrun;

  modport master (
    output start, continuous, abort, ch_mask, sar_data, res_ready,
    input  ch_sel, sample, sar_rst, res_data, res_ch, res_valid,
           busy, scan_done, overrun
  );

  modport slave (
    input  start, continuous, abort, ch_mask, sar_data, res_ready,
    output ch_sel, sample, sar_rst, res_data, res_ch, res_valid,
           busy, scan_done, overrun
  );
endinterface

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel SAR conversion sequencer.
// Walks the set bits of a latched channel mask. For each channel it
// settles the mux, tracks with sample high, releases sar_logic from reset
// for PRECISION+2 cycles and stores the result in a one-entry tagged
// valid/ready output register.
// Optional feature macro: SAR_SCAN_OVR_DROP_EN
//   defined   : STORE never waits; an unconsumed result is overwritten and
//               the sticky overrun flag is set.
//   undefined : STORE holds (sar_rst high) until the output slot is free;
//               overrun stays 0.
module sar_scan_ctrl #(
  parameter int PRECISION     = 10,
  parameter int NUM_CH        = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  sar_scan_if.slave bus
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int CONV_W = $clog2(PRECISION + 3);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int SAM_W  = $clog2(SAMPLE_CYCLES + 1);
  localparam int PH_W   = (SET_W > SAM_W) ? SET_W : SAM_W;

  // Counters load length-1 and leave the phase when they reach zero.
  localparam logic [PH_W-1:0]   SETTLE_LD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]   SAMPLE_LD = PH_W'(SAMPLE_CYCLES - 1);
  localparam logic [CONV_W-1:0] CONV_LD   = CONV_W'(PRECISION + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SAMPLE,
    S_CONVERT,
    S_STORE
  } state_t;

  state_t               state, state_nx;
  logic [PH_W-1:0]      ph_cnt, ph_cnt_nx;
  logic [CONV_W-1:0]    conv_cnt, conv_cnt_nx;
  logic [NUM_CH-1:0]    mask_q, mask_nx;
  logic [CH_W-1:0]      ch_q, ch_nx;
  logic                 sample_q, sample_nx;
  logic                 sar_rst_q, sar_rst_nx;
  logic                 done_q, done_nx;
  logic                 store_wait, store_wait_nx;
  logic                 res_valid_q;
  logic [PRECISION-1:0] res_data_q;
  logic [CH_W-1:0]      res_ch_q;
  logic                 overrun_q;
  logic [PRECISION-1:0] pend_data;

  logic                 capture;
  logic                 ovr_set;
  logic                 slot_free;
  logic [PRECISION-1:0] cap_data;
  logic [NUM_CH-1:0]    above;
  logic                 has_next;
  logic [CH_W-1:0]      next_ch;
  logic [CH_W-1:0]      first_ch;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // Mask bits strictly above the current channel.
  function automatic logic [NUM_CH-1:0] bits_above(input logic [NUM_CH-1:0] m,
                                                   input logic [CH_W-1:0]   cur);
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) begin
      r[i] = m[i] && (i > int'(cur));
    end
    return r;
  endfunction

  assign above    = bits_above(mask_q, ch_q);
  assign has_next = |above;
  assign next_ch  = lowest_set(above);
  assign first_ch = lowest_set(bus.ch_mask);

`ifdef SAR_SCAN_OVR_DROP_EN
  assign slot_free = 1'b1;
`else
  assign slot_free = !res_valid_q || bus.res_ready;
`endif

  // sar_logic clears on the first STORE edge, so a stalled STORE replays
  // the value it saw on that edge instead of the live SAR output.
  assign cap_data = store_wait ? pend_data : bus.sar_data;

  // Next-state, phase counters, channel walk and registered output controls.
  always_comb begin
    state_nx      = state;
    ph_cnt_nx     = ph_cnt;
    conv_cnt_nx   = conv_cnt;
    mask_nx       = mask_q;
    ch_nx         = ch_q;
    sample_nx     = sample_q;
    sar_rst_nx    = sar_rst_q;
    done_nx       = 1'b0;
    store_wait_nx = store_wait;
    capture       = 1'b0;
    ovr_set       = 1'b0;

    if (bus.abort) begin
      state_nx      = S_IDLE;
      mask_nx       = '0;
      sample_nx     = 1'b0;
      sar_rst_nx    = 1'b1;
      store_wait_nx = 1'b0;
      ph_cnt_nx     = '0;
      conv_cnt_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          sample_nx  = 1'b0;
          sar_rst_nx = 1'b1;
          if (bus.start && (|bus.ch_mask)) begin
            mask_nx   = bus.ch_mask;
            ch_nx     = first_ch;
            ph_cnt_nx = SETTLE_LD;
            state_nx  = S_SELECT;
          end
        end
        S_SELECT: begin
          if (ph_cnt == '0) begin
            ph_cnt_nx = SAMPLE_LD;
            sample_nx = 1'b1;
            state_nx  = S_SAMPLE;
          end else begin
            ph_cnt_nx = ph_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          if (ph_cnt == '0) begin
            conv_cnt_nx = CONV_LD;
            sample_nx   = 1'b0;
            sar_rst_nx  = 1'b0;
            state_nx    = S_CONVERT;
          end else begin
            ph_cnt_nx = ph_cnt - 1'b1;
          end
        end
        S_CONVERT: begin
          if (conv_cnt == '0) begin
            sar_rst_nx    = 1'b1;
            store_wait_nx = 1'b0;
            state_nx      = S_STORE;
          end else begin
            conv_cnt_nx = conv_cnt - 1'b1;
          end
        end
        S_STORE: begin
          if (slot_free) begin
            capture       = 1'b1;
            store_wait_nx = 1'b0;
`ifdef SAR_SCAN_OVR_DROP_EN
            ovr_set       = res_valid_q && !bus.res_ready;
`endif
            if (has_next) begin
              ch_nx     = next_ch;
              ph_cnt_nx = SETTLE_LD;
              state_nx  = S_SELECT;
            end else begin
              done_nx = 1'b1;
              if (bus.continuous && (|bus.ch_mask)) begin
                mask_nx   = bus.ch_mask;
                ch_nx     = first_ch;
                ph_cnt_nx = SETTLE_LD;
                state_nx  = S_SELECT;
              end else begin
                mask_nx  = '0;
                state_nx = S_IDLE;
              end
            end
          end else begin
            store_wait_nx = 1'b1;
          end
        end
        default: begin
          sample_nx  = 1'b0;
          sar_rst_nx = 1'b1;
          state_nx   = S_IDLE;
        end
      endcase
    end
  end

  // Sequencer state and the registered analog/SAR controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ph_cnt     <= '0;
      conv_cnt   <= '0;
      mask_q     <= '0;
      ch_q       <= '0;
      sample_q   <= 1'b0;
      sar_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      store_wait <= 1'b0;
    end else begin
      state      <= state_nx;
      ph_cnt     <= ph_cnt_nx;
      conv_cnt   <= conv_cnt_nx;
      mask_q     <= mask_nx;
      ch_q       <= ch_nx;
      sample_q   <= sample_nx;
      sar_rst_q  <= sar_rst_nx;
      done_q     <= done_nx;
      store_wait <= store_wait_nx;
    end
  end

  // Hold the SAR value seen on the first STORE edge for a stalled capture.
  always_ff @(posedge clk) begin
    if ((state == S_STORE) && !store_wait) begin
      pend_data <= bus.sar_data;
    end
  end

  // One-entry result slot; a capture wins over a same-edge consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= cap_data;
      res_ch_q    <= ch_q;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // Sticky overrun: cleared by a start accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if ((state == S_IDLE) && bus.start && !bus.abort) begin
      overrun_q <= 1'b0;
    end else if (ovr_set) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.ch_sel    = ch_q;
  assign bus.sample    = sample_q;
  assign bus.sar_rst   = sar_rst_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.scan_done = done_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench for sar_scan_ctrl with a behavioural SAR model and a
// result scoreboard. Inputs change 1 time unit after the rising edge;
// the scoreboard samples the handshake on the falling edge.
module tb_sar_scan_ctrl;
  localparam int PRECISION = 10;
  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_scan_if #(.PRECISION(PRECISION), .NUM_CH(NUM_CH)) bus ();

  sar_scan_ctrl #(
    .PRECISION(PRECISION),
    .NUM_CH(NUM_CH),
    .SETTLE_CYCLES(2),
    .SAMPLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // SAR model: steps while released, final value after step PRECISION+1,
  // clears whenever held in reset. Intermediate steps return a marker.
  logic [3:0]           sar_cnt;
  logic [PRECISION-1:0] sar_val;
  logic                 tag_xor;

  always @(posedge clk) begin
    if (bus.sar_rst) begin
      sar_cnt      <= '0;
      bus.sar_data <= '0;
    end else begin
      sar_cnt <= sar_cnt + 4'd1;
      if (int'(sar_cnt) == PRECISION + 1)
        bus.sar_data <= sar_val ^ (tag_xor ? PRECISION'(bus.ch_sel) : '0);
      else
        bus.sar_data <= 10'h200 | PRECISION'(sar_cnt);
    end
  end

  typedef struct {
    logic [PRECISION-1:0] data;
    logic [CH_W-1:0]      ch;
    int                   cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.scan_done === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  // Scoreboard: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin : pop
      exp_t e;
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_result observed ch %0d data %0h expected none",
               bus.res_ch, bus.res_data);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e.data));
        chk("res_ch", 32'(bus.res_ch), 32'(e.ch));
        chk("res_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int c;
    int at;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.abort      = 1'b0;
    bus.ch_mask    = '0;
    bus.res_ready  = 1'b1;
    sar_val        = 10'h2A5;
    tag_xor        = 1'b0;

    // Reset values, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ch_sel", 32'(bus.ch_sel), 32'd0);
    chk("rst_sample", 32'(bus.sample), 32'd0);
    chk("rst_sar_rst", 32'(bus.sar_rst), 32'd1);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_ch", 32'(bus.res_ch), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_scan_done", 32'(bus.scan_done), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single pass over channels 0 and 2; mid-pass mask change is ignored.
    c = cyc;
    sbq.push_back('{data: 10'h2A5, ch: 2'd0, cyc: c + 20});
    sbq.push_back('{data: 10'h2A5, ch: 2'd2, cyc: c + 39});
    bus.ch_mask = 4'b0101;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.ch_mask = 4'b1111;
    chk("t1_busy", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 19; k++) begin
      chk("t1_sample", 32'(bus.sample), 32'(k >= 3 && k <= 6));
      chk("t1_sar_rst", 32'(bus.sar_rst), 32'(!(k >= 7 && k <= 18)));
      chk("t1_ch_sel", 32'(bus.ch_sel), 32'd0);
      tick();
    end
    chk("t1_next_ch", 32'(bus.ch_sel), 32'd2);
    chk("t1_valid", 32'(bus.res_valid), 32'd1);
    chk("t1_busy_mid", 32'(bus.busy), 32'd1);
    wait_done(60, at);
    chk("t1_done_cycle", 32'(at), 32'(c + 39));
    chk("t1_done_ch", 32'(bus.res_ch), 32'd2);
    chk("t1_busy_end", 32'(bus.busy), 32'd0);
    tick();
    chk("t1_valid_end", 32'(bus.res_valid), 32'd0);

    // Empty mask: start is ignored.
    bus.ch_mask = 4'b0000;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_busy", 32'(bus.busy), 32'd0);
      tick();
    end

    // Continuous scan of channel 3, stopped after the third pass.
    tag_xor        = 1'b1;
    sar_val        = 10'h155;
    bus.continuous = 1'b1;
    c = cyc;
    sbq.push_back('{data: 10'h156, ch: 2'd3, cyc: c + 20});
    sbq.push_back('{data: 10'h156, ch: 2'd3, cyc: c + 39});
    sbq.push_back('{data: 10'h156, ch: 2'd3, cyc: c + 58});
    bus.ch_mask = 4'b1000;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(40, at);
    chk("t3_done1", 32'(at), 32'(c + 20));
    wait_done(40, at);
    chk("t3_done2", 32'(at), 32'(c + 39));
    bus.continuous = 1'b0;
    wait_done(40, at);
    chk("t3_done3", 32'(at), 32'(c + 58));
    chk("t3_busy_end", 32'(bus.busy), 32'd0);
    repeat (25) tick();
    chk("t3_stopped", 32'(bus.busy), 32'd0);

    // Abort in the fifth CONVERT cycle, then a normal conversion.
    c = cyc;
    bus.ch_mask = 4'b0001;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick_to(c + 11);
    chk("t4_in_convert", 32'(bus.sar_rst), 32'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_sar_rst", 32'(bus.sar_rst), 32'd1);
    chk("t4_sample", 32'(bus.sample), 32'd0);
    chk("t4_valid", 32'(bus.res_valid), 32'd0);
    repeat (30) tick();
    chk("t4_idle", 32'(bus.busy), 32'd0);
    c = cyc;
    sbq.push_back('{data: 10'h154, ch: 2'd1, cyc: c + 20});
    bus.ch_mask = 4'b0010;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(40, at);
    chk("t4_restart_done", 32'(at), 32'(c + 20));

    // Back-pressure: consumer not ready while two results are produced.
    tick();
    sar_val       = 10'h0F0;
    bus.res_ready = 1'b0;
    c = cyc;
`ifdef SAR_SCAN_OVR_DROP_EN
    sbq.push_back('{data: 10'h0F1, ch: 2'd1, cyc: c + 45});
`else
    sbq.push_back('{data: 10'h0F0, ch: 2'd0, cyc: c + 45});
    sbq.push_back('{data: 10'h0F1, ch: 2'd1, cyc: c + 46});
`endif
    bus.ch_mask = 4'b0011;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick_to(c + 21);
    chk("t5_first_valid", 32'(bus.res_valid), 32'd1);
    chk("t5_first_ch", 32'(bus.res_ch), 32'd0);
    tick_to(c + 45);
`ifdef SAR_SCAN_OVR_DROP_EN
    chk("t5_replaced_ch", 32'(bus.res_ch), 32'd1);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_overrun", 32'(bus.overrun), 32'd1);
`else
    chk("t5_held_ch", 32'(bus.res_ch), 32'd0);
    chk("t5_stall_busy", 32'(bus.busy), 32'd1);
    chk("t5_stall_sar_rst", 32'(bus.sar_rst), 32'd1);
    chk("t5_overrun", 32'(bus.overrun), 32'd0);
`endif
    bus.res_ready = 1'b1;
    tick();
`ifdef SAR_SCAN_OVR_DROP_EN
    chk("t5_drained", 32'(bus.res_valid), 32'd0);
`else
    chk("t5_second_valid", 32'(bus.res_valid), 32'd1);
    chk("t5_second_ch", 32'(bus.res_ch), 32'd1);
    chk("t5_done", 32'(bus.scan_done), 32'd1);
`endif
    repeat (3) tick();

    // Asynchronous reset in the middle of SAMPLE.
    c = cyc;
    bus.ch_mask = 4'b0100;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t6_overrun_clr", 32'(bus.overrun), 32'd0);
    tick_to(c + 4);
    chk("t6_sampling", 32'(bus.sample), 32'd1);
    chk("t6_ch_sel", 32'(bus.ch_sel), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sample", 32'(bus.sample), 32'd0);
    chk("t6_sar_rst", 32'(bus.sar_rst), 32'd1);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ch_sel_rst", 32'(bus.ch_sel), 32'd0);
    chk("t6_res_data", 32'(bus.res_data), 32'd0);
    chk("t6_res_ch", 32'(bus.res_ch), 32'd0);
    chk("t6_res_valid", 32'(bus.res_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    chk("t6_idle", 32'(bus.busy), 32'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
